video_timing_gen: RTL



---
 rtl/video_timing_pkg.sv | 60 ++++++
 rtl/sig_delay.sv | 38 +++
 rtl/video_timing_gen.sv | 111 +++++++++++
 3 files changed

// File: rtl/video_timing_pkg.sv
// Shared raster constants, count widths and the sync/active decode used by the
// timing generator and by any reference model of it.
package video_timing_pkg;

  localparam int H_ACTIVE_720P = 1280;
  localparam int H_FP_720P     = 110;
  localparam int H_SYNC_720P   = 40;
  localparam int H_BP_720P     = 220;
  localparam int V_ACTIVE_720P = 720;
  localparam int V_FP_720P     = 5;
  localparam int V_SYNC_720P   = 5;
  localparam int V_BP_720P     = 20;
  localparam int H_TOTAL_720P  = H_ACTIVE_720P + H_FP_720P + H_SYNC_720P + H_BP_720P;
  localparam int V_TOTAL_720P  = V_ACTIVE_720P + V_FP_720P + V_SYNC_720P + V_BP_720P;

  localparam int H_CNT_W = 11;
  localparam int V_CNT_W = 10;
  localparam int FC_W    = 6;

  typedef struct packed {
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_active;
    int v_fp;
    int v_sync;
    int v_bp;
  } timing_t;

  // Bit order hs, vs, ad is relied upon wherever flags are packed into a vector.
  typedef struct packed {
    logic hs;
    logic vs;
    logic ad;
  } flags_t;

  function automatic int h_total(input timing_t t);
    return t.h_active + t.h_fp + t.h_sync + t.h_bp;
  endfunction

  function automatic int v_total(input timing_t t);
    return t.v_active + t.v_fp + t.v_sync + t.v_bp;
  endfunction

  function automatic flags_t timing_flags(input timing_t t,
                                          input logic [H_CNT_W-1:0] h,
                                          input logic [V_CNT_W-1:0] v);
    flags_t f;
    int     hi;
    int     vi;
    hi   = int'(h);
    vi   = int'(v);
    f.hs = (hi >= t.h_active + t.h_fp) && (hi < t.h_active + t.h_fp + t.h_sync);
    f.vs = (vi >= t.v_active + t.v_fp) && (vi < t.v_active + t.v_fp + t.v_sync);
    f.ad = (hi < t.h_active) && (vi < t.v_active);
    return f;
  endfunction

endpackage

// File: rtl/sig_delay.sv
// Fixed-latency shift register; DEPTH=0 degenerates to a plain wire.
module sig_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk_in ^ rst_in;
    assign q = d;
  end else begin : g_pipe
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] stage_reg;
      logic [WIDTH-1:0] stage_next;

      if (gi == 0) begin : g_first
        assign stage_next = d;
      end else begin : g_rest
        assign stage_next = g_stage[gi-1].stage_reg;
      end

      always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
          stage_reg <= '0;
        end else begin
          stage_reg <= stage_next;
        end
      end
    end
    assign q = g_stage[DEPTH-1].stage_reg;
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster counter with registered sync/active/new-frame flags, frame counter and
// a latency-matched copy of {hs, vs, ad} for the TMDS encoders.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_720P,
  parameter int H_FP       = H_FP_720P,
  parameter int H_SYNC     = H_SYNC_720P,
  parameter int H_BP       = H_BP_720P,
  parameter int V_ACTIVE   = V_ACTIVE_720P,
  parameter int V_FP       = V_FP_720P,
  parameter int V_SYNC     = V_SYNC_720P,
  parameter int V_BP       = V_BP_720P,
  parameter int FRAME_WRAP = 60,
  parameter int DLY        = 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  output logic [H_CNT_W-1:0] hcount_out,
  output logic [V_CNT_W-1:0] vcount_out,
  output logic               hs_out,
  output logic               vs_out,
  output logic               ad_out,
  output logic               nf_out,
  output logic [FC_W-1:0]    fc_out,
  output logic               hs_dly_out,
  output logic               vs_dly_out,
  output logic               ad_dly_out
);

  localparam timing_t CFG = '{
    h_active: H_ACTIVE, h_fp: H_FP, h_sync: H_SYNC, h_bp: H_BP,
    v_active: V_ACTIVE, v_fp: V_FP, v_sync: V_SYNC, v_bp: V_BP
  };
  localparam int H_TOTAL = h_total(CFG);
  localparam int V_TOTAL = v_total(CFG);

  localparam logic [H_CNT_W-1:0] H_LAST  = H_CNT_W'(H_TOTAL - 1);
  localparam logic [V_CNT_W-1:0] V_LAST  = V_CNT_W'(V_TOTAL - 1);
  localparam logic [H_CNT_W-1:0] NF_H    = H_CNT_W'(H_ACTIVE);
  localparam logic [V_CNT_W-1:0] NF_V    = V_CNT_W'(V_ACTIVE);
  localparam logic [FC_W-1:0]    FC_LAST = FC_W'(FRAME_WRAP - 1);

  if (H_TOTAL > 2048 || V_TOTAL > 1024 || FRAME_WRAP < 1 || FRAME_WRAP > 64 || DLY < 0)
  begin : g_param_check
    $error("video_timing_gen: timing parameters do not fit the counter widths");
  end

  logic [H_CNT_W-1:0] hcount_reg, hcount_next;
  logic [V_CNT_W-1:0] vcount_reg, vcount_next;
  logic [FC_W-1:0]    fc_reg, fc_next;
  flags_t             flags_reg, flags_next;
  logic               nf_reg, nf_next;
  logic               line_end;
  logic [2:0]         flags_dly;

  // Flags decode the next position so they land in the same cycle as the counters.
  always_comb begin
    line_end    = (hcount_reg == H_LAST);
    hcount_next = line_end ? '0 : hcount_reg + H_CNT_W'(1);
    vcount_next = vcount_reg;
    if (line_end) begin
      vcount_next = (vcount_reg == V_LAST) ? '0 : vcount_reg + V_CNT_W'(1);
    end
    flags_next = timing_flags(CFG, hcount_next, vcount_next);
    nf_next    = (hcount_next == NF_H) && (vcount_next == NF_V);
    fc_next    = fc_reg;
    if (nf_next) begin
      fc_next = (fc_reg == FC_LAST) ? '0 : fc_reg + FC_W'(1);
    end
  end

  // Reset parks at the last blanking pixel so the first edge lands on (0,0).
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      hcount_reg <= H_LAST;
      vcount_reg <= V_LAST;
      flags_reg  <= '0;
      nf_reg     <= 1'b0;
      fc_reg     <= '0;
    end else begin
      hcount_reg <= hcount_next;
      vcount_reg <= vcount_next;
      flags_reg  <= flags_next;
      nf_reg     <= nf_next;
      fc_reg     <= fc_next;
    end
  end

  sig_delay #(
    .WIDTH(3),
    .DEPTH(DLY)
  ) u_flags_dly (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .d     (flags_reg),
    .q     (flags_dly)
  );

  assign hcount_out = hcount_reg;
  assign vcount_out = vcount_reg;
  assign hs_out     = flags_reg.hs;
  assign vs_out     = flags_reg.vs;
  assign ad_out     = flags_reg.ad;
  assign nf_out     = nf_reg;
  assign fc_out     = fc_reg;
  assign hs_dly_out = flags_dly[2];
  assign vs_dly_out = flags_dly[1];
  assign ad_dly_out = flags_dly[0];

endmodule
